// File: rtl/pipe_cmd_pkg.sv
// rtl/pipe_cmd_pkg.sv - PowerDown encodings, request kinds and FSM states for the PIPE command sequencer
package pipe_cmd_pkg;

    localparam logic [3:0] PD_P0  = 4'h0;
    localparam logic [3:0] PD_P0S = 4'h1;
    localparam logic [3:0] PD_P1  = 4'h2;
    localparam logic [3:0] PD_P2  = 4'h3;

    typedef enum logic {REQ_PD, REQ_RATE} req_kind_e;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        EIDLE,
        APPLY,
        WAIT,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/pipe_phystatus_collector.sv
// rtl/pipe_phystatus_collector.sv - sticky per-lane PhyStatus ack collector
module pipe_phystatus_collector #(
    parameter int NUM_LANES = 16
) (
    input  logic                 PCLK,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic [NUM_LANES-1:0] mask,
    input  logic [NUM_LANES-1:0] PhyStatus,
    output logic [NUM_LANES-1:0] ack_q,
    output logic                 all_acked
);

    always_ff @(posedge PCLK) begin
        if (Reset || clear) begin
            ack_q <= '0;
        end else begin
            ack_q <= ack_q | (PhyStatus & mask);
        end
    end

    // Includes this cycle's pulses so a final ack is seen in the cycle it arrives.
    assign all_acked = ((ack_q | (PhyStatus & mask)) == mask);

endmodule

// File: rtl/pipe_cmd_sequencer.sv
// rtl/pipe_cmd_sequencer.sv - MAC-side PIPE PowerDown/Rate command sequencer with PhyStatus timeout
import pipe_cmd_pkg::*;

module pipe_cmd_sequencer #(
    parameter int NUM_LANES      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   PCLK,
    input  logic                   Reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_kind,
    input  logic [3:0]             req_powerdown,
    input  logic [3:0]             req_rate,
    input  logic [NUM_LANES-1:0]   lane_en,
    output logic [4*NUM_LANES-1:0] PowerDown,
    output logic [3:0]             Rate,
    output logic [NUM_LANES-1:0]   force_elec_idle,
    input  logic [NUM_LANES-1:0]   PhyStatus,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [NUM_LANES-1:0]   mask_q;
    logic [4*NUM_LANES-1:0] pd_q;
    logic [3:0]             rate_q;
    logic [3:0]             rate_pend_q;
    logic                   force_q;
    logic [CW-1:0]          cnt_q;
    logic                   done_q;
    logic                   error_q;
    logic                   no_change;
    logic                   all_acked;
    logic [NUM_LANES-1:0]   ack_q;

    pipe_phystatus_collector #(.NUM_LANES(NUM_LANES)) u_collector (
        .PCLK      (PCLK),
        .Reset     (Reset),
        .clear     (state_q == APPLY),
        .mask      (mask_q),
        .PhyStatus (PhyStatus),
        .ack_q     (ack_q),
        .all_acked (all_acked)
    );

    always_comb begin
        no_change = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_en[i] && (req_kind == REQ_PD) && (pd_q[4*i +: 4] != req_powerdown)) begin
                no_change = 1'b0;
            end
        end
        if ((req_kind == REQ_RATE) && (rate_q != req_rate)) begin
            no_change = 1'b0;
        end
        if (lane_en == '0) begin
            no_change = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_WAIT: if ((PhyStatus & lane_en) == '0) state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    if (no_change)                 state_d = DONE;
                    else if (req_kind == REQ_RATE) state_d = EIDLE;
                    else                           state_d = APPLY;
                end
            end
            EIDLE: state_d = APPLY;
            APPLY: state_d = WAIT;
            WAIT: begin
                if (all_acked)              state_d = DONE;
                else if (cnt_q == CNT_LAST) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (Reset) begin
            state_q     <= RST_WAIT;
            mask_q      <= '0;
            pd_q        <= {NUM_LANES{PD_P1}};
            rate_q      <= '0;
            rate_pend_q <= '0;
            force_q     <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DONE);
            error_q <= (state_q == ERR);
            if (state_q == IDLE && req_valid) begin
                mask_q      <= lane_en;
                rate_pend_q <= req_rate;
            end
            // PowerDown enters APPLY straight from IDLE, Rate only via EIDLE.
            if (state_d == APPLY) begin
                if (state_q == IDLE) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (lane_en[i]) pd_q[4*i +: 4] <= req_powerdown;
                    end
                end else begin
                    rate_q <= rate_pend_q;
                end
            end
            if (state_d == EIDLE)     force_q <= 1'b1;
            else if (state_d == IDLE) force_q <= 1'b0;
            if (state_q == APPLY) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign error           = error_q;
    assign PowerDown       = pd_q;
    assign Rate            = rate_q;
    assign force_elec_idle = force_q ? mask_q : '0;

endmodule

// File: tb/tb_pipe_cmd_sequencer.sv
// tb/tb_pipe_cmd_sequencer.sv - directed self-checking bench for pipe_cmd_sequencer
module tb_pipe_cmd_sequencer;

    localparam int NL = 16;

    logic            PCLK = 1'b0;
    logic            Reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_kind = 1'b0;
    logic [3:0]      req_powerdown = 4'h0;
    logic [3:0]      req_rate = 4'h0;
    logic [NL-1:0]   lane_en = 16'hFFFF;
    logic [4*NL-1:0] PowerDown;
    logic [3:0]      Rate;
    logic [NL-1:0]   force_elec_idle;
    logic [NL-1:0]   PhyStatus = 16'hFFFF;
    logic            busy;
    logic            done;
    logic            error;

    int checks = 0;
    int errors = 0;

    pipe_cmd_sequencer #(.NUM_LANES(NL), .TIMEOUT_CYCLES(8)) dut (
        .PCLK            (PCLK),
        .Reset           (Reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_kind        (req_kind),
        .req_powerdown   (req_powerdown),
        .req_rate        (req_rate),
        .lane_en         (lane_en),
        .PowerDown       (PowerDown),
        .Rate            (Rate),
        .force_elec_idle (force_elec_idle),
        .PhyStatus       (PhyStatus),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic pulses(input string tag, input logic exp_done, input logic exp_err);
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
    endtask

    task automatic issue(input logic kind, input logic [3:0] pd, input logic [3:0] rate, input logic [NL-1:0] en);
        req_kind = kind; req_powerdown = pd; req_rate = rate; lane_en = en; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_pd", PowerDown, 64'h2222_2222_2222_2222);
        chk("rst_rate", 64'(Rate), 64'd0);
        chk("rst_force", 64'(force_elec_idle), 64'd0);
        pulses("rst", 1'b0, 1'b0);

        // 1: stay in RST_WAIT while PhyStatus is high
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_wait_ready", 64'(req_ready), 64'd0);
        end
        PhyStatus = '0;
        tick();
        chk("t1_ready", 64'(req_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: PowerDown P0 on lanes 0..3, staggered acks
        issue(1'b0, 4'h0, 4'h0, 16'h000F);
        chk("t2_pd", PowerDown, 64'h2222_2222_2222_0000);
        chk("t2_ready", 64'(req_ready), 64'd0);
        PhyStatus = 16'h0001; tick();
        PhyStatus = 16'h0001; tick();
        PhyStatus = 16'h0022; tick();
        PhyStatus = 16'h0004; tick();
        PhyStatus = 16'h0000; tick();
        pulses("t2_pre", 1'b0, 1'b0);
        PhyStatus = 16'h0008; tick();
        PhyStatus = 16'h0000;
        pulses("t2_wd", 1'b0, 1'b0);
        chk("t2_busy", 64'(busy), 64'd1);
        tick();
        pulses("t2_done", 1'b1, 1'b0);
        tick();
        pulses("t2_after", 1'b0, 1'b0);
        chk("t2_ready2", 64'(req_ready), 64'd1);

        // 3: Rate 1 on all lanes
        issue(1'b1, 4'h0, 4'h1, 16'hFFFF);
        chk("t3_force", 64'(force_elec_idle), 64'hFFFF);
        chk("t3_rate_n1", 64'(Rate), 64'd0);
        tick();
        chk("t3_rate_n2", 64'(Rate), 64'd1);
        tick();
        PhyStatus = 16'hFFFF; tick();
        PhyStatus = 16'h0000;
        pulses("t3_wd", 1'b0, 1'b0);
        chk("t3_force_done", 64'(force_elec_idle), 64'hFFFF);
        tick();
        pulses("t3_done", 1'b1, 1'b0);
        chk("t3_force_idle", 64'(force_elec_idle), 64'd0);

        // 4: PowerDown P2 on lanes 4,5; lane 5 never acks
        issue(1'b0, 4'h3, 4'h0, 16'h0030);
        chk("t4_pd", PowerDown, 64'h2222_2222_2233_0000);
        tick();
        PhyStatus = 16'h0010; tick();
        PhyStatus = 16'h0000;
        pulses("t4_w", 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            pulses("t4_w", 1'b0, 1'b0);
        end
        tick();
        pulses("t4_err", 1'b0, 1'b1);
        chk("t4_pd_kept", PowerDown, 64'h2222_2222_2233_0000);
        tick();
        chk("t4_ready", 64'(req_ready), 64'd1);
        pulses("t4_after", 1'b0, 1'b0);

        // 5: no-change requests
        issue(1'b0, 4'h3, 4'h0, 16'h0030);
        pulses("t5a_n1", 1'b0, 1'b0);
        chk("t5a_force", 64'(force_elec_idle), 64'd0);
        tick();
        pulses("t5a_n2", 1'b1, 1'b0);
        chk("t5a_pd", PowerDown, 64'h2222_2222_2233_0000);
        issue(1'b1, 4'h0, 4'h1, 16'hFFFF);
        chk("t5b_force", 64'(force_elec_idle), 64'd0);
        tick();
        pulses("t5b_n2", 1'b1, 1'b0);
        issue(1'b1, 4'h0, 4'h5, 16'h0000);
        chk("t5c_force", 64'(force_elec_idle), 64'd0);
        tick();
        pulses("t5c_n2", 1'b1, 1'b0);
        chk("t5c_rate", 64'(Rate), 64'd1);

        // 6a: reset during WAIT aborts silently
        issue(1'b0, 4'h0, 4'h0, 16'hFFFF);
        tick();
        Reset = 1'b1; tick();
        pulses("t6a_rst", 1'b0, 1'b0);
        chk("t6a_pd", PowerDown, 64'h2222_2222_2222_2222);
        chk("t6a_rate", 64'(Rate), 64'd0);
        Reset = 1'b0; tick();
        chk("t6a_ready", 64'(req_ready), 64'd1);
        pulses("t6a_after", 1'b0, 1'b0);
        tick();
        pulses("t6a_after2", 1'b0, 1'b0);

        // 6b: final ack on the timeout cycle -> done wins
        issue(1'b0, 4'h1, 4'h0, 16'h0001);
        chk("t6b_pd", PowerDown, 64'h2222_2222_2222_2221);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            pulses("t6b_w", 1'b0, 1'b0);
        end
        PhyStatus = 16'h0001; tick();
        PhyStatus = 16'h0000;
        pulses("t6b_wd", 1'b0, 1'b0);
        tick();
        pulses("t6b_done", 1'b1, 1'b0);
        tick();
        pulses("t6b_after", 1'b0, 1'b0);
        chk("t6b_ready", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
